// File: rtl/dut_round_checker_pkg.sv
// ---------------------------------------------------------------------------
// dut_checker_pkg
//   Shared definitions for the accelerator round checker: the sequencer state
//   encoding and the default width constants used by the top level and the
//   word comparator.
//   Optional feature macro used by this slice: RESULT_TOL_EN (tolerance
//   compare instead of exact equality; see word_compare_unit).
// ---------------------------------------------------------------------------
package dut_checker_pkg;

    // Default geometry of the result / golden SRAMs and the counters
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_CYC_WIDTH   = 32;
    localparam int DEF_ROUND_WIDTH = 8;
    localparam int DEF_TOL         = 1;

    // Round sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_RUN       = 3'd2,
        ST_COMPUTE   = 3'd3,
        ST_SCAN      = 3'd4,
        ST_DRAIN     = 3'd5,
        ST_DONE      = 3'd6
    } checker_state_e;

endpackage

// File: rtl/dut_round_checker_compare.sv
// ---------------------------------------------------------------------------
// word_compare_unit
//   Combinational match decision for one result/golden word pair.
//   Macro RESULT_TOL_EN: when defined, words are signed and match when
//   |res - gold| <= TOL; otherwise exact bitwise equality is required.
// Ports:
//   i_resData   result SRAM word
//   i_goldData  golden SRAM word
//   o_match     1 when the pair is considered equal
// ---------------------------------------------------------------------------
module word_compare_unit
    import dut_checker_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TOL        = DEF_TOL
) (
    input  logic [DATA_WIDTH-1:0] i_resData,
    input  logic [DATA_WIDTH-1:0] i_goldData,
    output logic                  o_match
);

`ifdef RESULT_TOL_EN
    localparam bit TolEnable = 1'b1;
`else
    localparam bit TolEnable = 1'b0;
`endif

    localparam logic [DATA_WIDTH:0] TolLimit = (DATA_WIDTH+1)'(TOL);

    logic signed [DATA_WIDTH:0] w_diff;
    logic        [DATA_WIDTH:0] w_absDiff;
    logic                       w_withinTol;
    logic                       w_exact;

    // Sign-extend by one bit so the difference of two extreme values
    // cannot overflow; the magnitude then fits unsigned in the same width.
    assign w_diff      = $signed({i_resData[DATA_WIDTH-1], i_resData})
                       - $signed({i_goldData[DATA_WIDTH-1], i_goldData});
    assign w_absDiff   = w_diff[DATA_WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_withinTol = (w_absDiff <= TolLimit);
    assign w_exact     = (i_resData == i_goldData);

    assign o_match = TolEnable ? w_withinTol : w_exact;

endmodule

// File: rtl/dut_round_checker.sv
// ---------------------------------------------------------------------------
// dut_round_checker
//   Run/check sequencer for one accelerator round: waits for the DUT to be
//   idle, pulses dut_run, times the compute phase, then scans the result SRAM
//   against the golden SRAM and reports correct/mismatch counts.
//   Optional feature macro: RESULT_TOL_EN (tolerance compare, see
//   word_compare_unit).
// Ports:
//   clk, reset_b                 clock, asynchronous active-low reset
//   start                        begin a round (only honoured in IDLE)
//   base_addr, num_results       scan window (address wraps mod 2^ADDR_WIDTH)
//   timeout_cycles               abort limit for WAIT_IDLE/RUN/COMPUTE, 0 = off
//   dut_run / dut_busy           run handshake with the accelerator
//   res_read_*, gold_read_*      SRAM read ports, 1-cycle read latency
//   busy, done, pass             round status
//   timeout_flag                 round was aborted by timeout
//   correct_count, mismatch_count, first_mismatch_addr   scan results
//   compute_cycles               cycles from dut_run rise to dut_busy fall
//   round_count                  completed rounds (wraps)
// ---------------------------------------------------------------------------
module dut_round_checker
    import dut_checker_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CYC_WIDTH   = DEF_CYC_WIDTH,
    parameter int ROUND_WIDTH = DEF_ROUND_WIDTH,
    parameter int TOL         = DEF_TOL
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH:0]    num_results,
    input  logic [CYC_WIDTH-1:0]   timeout_cycles,
    output logic                   dut_run,
    input  logic                   dut_busy,
    output logic [ADDR_WIDTH-1:0]  res_read_address,
    input  logic [DATA_WIDTH-1:0]  res_read_data,
    output logic [ADDR_WIDTH-1:0]  gold_read_address,
    input  logic [DATA_WIDTH-1:0]  gold_read_data,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout_flag,
    output logic [ADDR_WIDTH:0]    correct_count,
    output logic [ADDR_WIDTH:0]    mismatch_count,
    output logic [ADDR_WIDTH-1:0]  first_mismatch_addr,
    output logic [CYC_WIDTH-1:0]   compute_cycles,
    output logic [ROUND_WIDTH-1:0] round_count
);

    localparam logic [ADDR_WIDTH:0]    CntOne   = 1;
    localparam logic [ADDR_WIDTH-1:0]  AddrOne  = 1;
    localparam logic [CYC_WIDTH-1:0]   CycOne   = 1;
    localparam logic [ROUND_WIDTH-1:0] RoundOne = 1;

    checker_state_e         r_state;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [ADDR_WIDTH:0]    r_num;
    logic [ADDR_WIDTH:0]    r_idx;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_cmpValid;
    logic [ADDR_WIDTH-1:0]  r_cmpAddr;
    logic [CYC_WIDTH-1:0]   r_timer;
    logic [CYC_WIDTH-1:0]   r_timeoutCycles;
    logic [CYC_WIDTH-1:0]   r_computeCycles;
    logic                   r_dutRun;
    logic                   r_done;
    logic                   r_pass;
    logic                   r_timeoutFlag;
    logic [ADDR_WIDTH:0]    r_correct;
    logic [ADDR_WIDTH:0]    r_mismatch;
    logic [ADDR_WIDTH-1:0]  r_firstMismatch;
    logic [ROUND_WIDTH-1:0] r_roundCount;

    logic                   w_match;
    logic [CYC_WIDTH-1:0]   w_timerNext;
    logic                   w_timerHit;
    logic                   w_lastIdx;

    word_compare_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .TOL        (TOL)
    ) u_compare (
        .i_resData  (res_read_data),
        .i_goldData (gold_read_data),
        .o_match    (w_match)
    );

    assign w_timerNext = r_timer + CycOne;
    assign w_timerHit  = (r_timeoutCycles != '0) && (w_timerNext == r_timeoutCycles);
    assign w_lastIdx   = (r_idx == (r_num - CntOne));

    // Sequencer plus compare stage. The SRAM registers the address at the end
    // of the cycle it is presented, so the data is compared one cycle later
    // through r_cmpValid/r_cmpAddr; DRAIN exists only to consume the last one.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state         <= ST_IDLE;
            r_base          <= '0;
            r_num           <= '0;
            r_idx           <= '0;
            r_addr          <= '0;
            r_cmpValid      <= 1'b0;
            r_cmpAddr       <= '0;
            r_timer         <= '0;
            r_timeoutCycles <= '0;
            r_computeCycles <= '0;
            r_dutRun        <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_timeoutFlag   <= 1'b0;
            r_correct       <= '0;
            r_mismatch      <= '0;
            r_firstMismatch <= '0;
            r_roundCount    <= '0;
        end else begin
            r_done     <= 1'b0;
            r_cmpValid <= 1'b0;

            if (r_cmpValid) begin
                if (w_match) begin
                    r_correct <= r_correct + CntOne;
                end else begin
                    r_mismatch <= r_mismatch + CntOne;
                    if (r_mismatch == '0) begin
                        r_firstMismatch <= r_cmpAddr;
                    end
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base          <= base_addr;
                        r_num           <= num_results;
                        r_timeoutCycles <= timeout_cycles;
                        r_timer         <= '0;
                        r_correct       <= '0;
                        r_mismatch      <= '0;
                        r_firstMismatch <= base_addr;
                        r_timeoutFlag   <= 1'b0;
                        r_pass          <= 1'b0;
                        r_computeCycles <= '0;
                        r_state         <= ST_WAIT_IDLE;
                    end
                end

                ST_WAIT_IDLE: begin
                    r_timer <= w_timerNext;
                    if (w_timerHit) begin
                        r_dutRun      <= 1'b0;
                        r_timeoutFlag <= 1'b1;
                        r_pass        <= 1'b0;
                        r_done        <= 1'b1;
                        r_roundCount  <= r_roundCount + RoundOne;
                        r_state       <= ST_DONE;
                    end else if (!dut_busy) begin
                        r_dutRun        <= 1'b1;
                        r_computeCycles <= '0;
                        r_state         <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_timer         <= w_timerNext;
                    r_computeCycles <= r_computeCycles + CycOne;
                    if (w_timerHit) begin
                        r_dutRun      <= 1'b0;
                        r_timeoutFlag <= 1'b1;
                        r_pass        <= 1'b0;
                        r_done        <= 1'b1;
                        r_roundCount  <= r_roundCount + RoundOne;
                        r_state       <= ST_DONE;
                    end else if (dut_busy) begin
                        r_dutRun <= 1'b0;
                        r_state  <= ST_COMPUTE;
                    end
                end

                ST_COMPUTE: begin
                    r_timer <= w_timerNext;
                    if (w_timerHit) begin
                        r_dutRun      <= 1'b0;
                        r_timeoutFlag <= 1'b1;
                        r_pass        <= 1'b0;
                        r_done        <= 1'b1;
                        r_roundCount  <= r_roundCount + RoundOne;
                        r_state       <= ST_DONE;
                    end else if (!dut_busy) begin
                        // compute_cycles freezes here: no increment on the busy-fall cycle
                        if (r_num == '0) begin
                            r_pass       <= 1'b1;
                            r_done       <= 1'b1;
                            r_roundCount <= r_roundCount + RoundOne;
                            r_state      <= ST_DONE;
                        end else begin
                            r_addr  <= r_base;
                            r_idx   <= '0;
                            r_state <= ST_SCAN;
                        end
                    end else begin
                        r_computeCycles <= r_computeCycles + CycOne;
                    end
                end

                ST_SCAN: begin
                    r_cmpValid <= 1'b1;
                    r_cmpAddr  <= r_addr;
                    if (w_lastIdx) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_addr <= r_addr + AddrOne;
                        r_idx  <= r_idx + CntOne;
                    end
                end

                ST_DRAIN: begin
                    // The final word is being compared on this same edge
                    r_pass       <= (r_mismatch == '0) && w_match;
                    r_done       <= 1'b1;
                    r_roundCount <= r_roundCount + RoundOne;
                    r_state      <= ST_DONE;
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dut_run             = r_dutRun;
    assign res_read_address    = r_addr;
    assign gold_read_address   = r_addr;
    assign busy                = (r_state != ST_IDLE);
    assign done                = r_done;
    assign pass                = r_pass;
    assign timeout_flag        = r_timeoutFlag;
    assign correct_count       = r_correct;
    assign mismatch_count      = r_mismatch;
    assign first_mismatch_addr = r_firstMismatch;
    assign compute_cycles      = r_computeCycles;
    assign round_count         = r_roundCount;

endmodule

// File: tb/tb_dut_round_checker.sv
// ---------------------------------------------------------------------------
// tb_dut_round_checker
//   Directed bench for dut_round_checker with a behavioural accelerator
//   (run/busy handshake) and two synchronous read SRAMs.
// ---------------------------------------------------------------------------
module tb_dut_round_checker;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] num_results;
    logic [31:0] timeout_cycles;
    logic        dut_run;
    logic        dut_busy = 1'b0;
    logic [11:0] res_read_address;
    logic [15:0] res_read_data;
    logic [11:0] gold_read_address;
    logic [15:0] gold_read_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout_flag;
    logic [12:0] correct_count;
    logic [12:0] mismatch_count;
    logic [11:0] first_mismatch_addr;
    logic [31:0] compute_cycles;
    logic [7:0]  round_count;

    int errorCount = 0;
    int checkCount = 0;

    logic [15:0] resMem  [4096];
    logic [15:0] goldMem [4096];

    // accelerator model controls
    int   busyCycles = 100;
    int   busyLeft   = 0;
    logic hangMode   = 1'b0;
    logic killBusy   = 1'b0;

    // address-change log of the result read port
    logic [11:0] addrLog [$];
    logic [11:0] lastAddr = 12'h000;

    dut_round_checker dut (
        .clk                 (clk),
        .reset_b             (reset_b),
        .start               (start),
        .base_addr           (base_addr),
        .num_results         (num_results),
        .timeout_cycles      (timeout_cycles),
        .dut_run             (dut_run),
        .dut_busy            (dut_busy),
        .res_read_address    (res_read_address),
        .res_read_data       (res_read_data),
        .gold_read_address   (gold_read_address),
        .gold_read_data      (gold_read_data),
        .busy                (busy),
        .done                (done),
        .pass                (pass),
        .timeout_flag        (timeout_flag),
        .correct_count       (correct_count),
        .mismatch_count      (mismatch_count),
        .first_mismatch_addr (first_mismatch_addr),
        .compute_cycles      (compute_cycles),
        .round_count         (round_count)
    );

    always #5 clk = ~clk;

    // synchronous SRAMs with one cycle of read latency
    always @(posedge clk) begin
        res_read_data  <= resMem[res_read_address];
        gold_read_data <= goldMem[gold_read_address];
    end

    // accelerator: goes busy after seeing run, stays busy busyCycles cycles
    always @(negedge clk) begin
        if (killBusy) begin
            dut_busy = 1'b0;
            busyLeft = 0;
        end else if (dut_run && !dut_busy) begin
            dut_busy = 1'b1;
            busyLeft = busyCycles;
        end else if (dut_busy && !hangMode) begin
            if (busyLeft <= 1) dut_busy = 1'b0;
            else busyLeft = busyLeft - 1;
        end
    end

    always @(negedge clk) begin
        if (res_read_address != lastAddr) begin
            addrLog.push_back(res_read_address);
            lastAddr = res_read_address;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // pulse start for one cycle and wait (bounded) for done; on return the
    // bench sits at the negedge of the DONE cycle
    task automatic applyStimulus(input string tag, input logic [11:0] base,
                                 input logic [12:0] num, input logic [31:0] tmo,
                                 output int cycles);
        @(negedge clk);
        base_addr      = base;
        num_results    = num;
        timeout_cycles = tmo;
        start          = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_doneSeen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic checkDonePulse(input string tag);
        @(negedge clk);
        checkOutput({tag, "_donePulse"}, {31'd0, done}, 32'd0);
    endtask

    int cyc;
    int expCorrect;
    int expMismatch;
    int expFirst;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            goldMem[i] = 16'(i * 7 + 3);
            resMem[i]  = 16'(i * 7 + 3);
        end
        reset_b        = 1'b0;
        start          = 1'b0;
        base_addr      = 12'h000;
        num_results    = 13'd0;
        timeout_cycles = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("rst_done",    {31'd0, done},    32'd0);
        checkOutput("rst_busy",    {31'd0, busy},    32'd0);
        checkOutput("rst_dutRun",  {31'd0, dut_run}, 32'd0);
        checkOutput("rst_pass",    {31'd0, pass},    32'd0);
        checkOutput("rst_rounds",  32'(round_count), 32'd0);
        checkOutput("rst_correct", 32'(correct_count), 32'd0);
        checkOutput("rst_addr",    32'(res_read_address), 32'd0);
        reset_b = 1'b1;

        // 1: clean round of 72 words, 100-cycle compute
        busyCycles = 100;
        applyStimulus("t1", 12'h000, 13'd72, 32'd0, cyc);
        checkOutput("t1_pass",     {31'd0, pass}, 32'd1);
        checkOutput("t1_correct",  32'(correct_count), 32'd72);
        checkOutput("t1_mismatch", 32'(mismatch_count), 32'd0);
        checkOutput("t1_first",    32'(first_mismatch_addr), 32'd0);
        checkOutput("t1_ccRange",  {31'd0, (compute_cycles >= 32'd100 && compute_cycles <= 32'd102)}, 32'd1);
        checkOutput("t1_rounds",   32'(round_count), 32'd1);
        checkOutput("t1_timeout",  {31'd0, timeout_flag}, 32'd0);
        checkDonePulse("t1");

        // 2: words 5 and 40 corrupted
        resMem[5]  = resMem[5] ^ 16'h00FF;
        resMem[40] = resMem[40] ^ 16'h0001;
        busyCycles = 20;
        applyStimulus("t2", 12'h000, 13'd72, 32'd0, cyc);
        checkOutput("t2_pass",     {31'd0, pass}, 32'd0);
        checkOutput("t2_correct",  32'(correct_count), 32'd70);
        checkOutput("t2_mismatch", 32'(mismatch_count), 32'd2);
        checkOutput("t2_first",    32'(first_mismatch_addr), 32'd5);
        checkOutput("t2_rounds",   32'(round_count), 32'd2);
        resMem[5]  = goldMem[5];
        resMem[40] = goldMem[40];

        // 3: window wrapping past the top of the address space
        addrLog.delete();
        applyStimulus("t3", 12'hFFE, 13'd4, 32'd0, cyc);
        checkOutput("t3_logSize",  32'(addrLog.size()), 32'd4);
        if (addrLog.size() == 4) begin
            checkOutput("t3_addr0", 32'(addrLog[0]), 32'hFFE);
            checkOutput("t3_addr1", 32'(addrLog[1]), 32'hFFF);
            checkOutput("t3_addr2", 32'(addrLog[2]), 32'h000);
            checkOutput("t3_addr3", 32'(addrLog[3]), 32'h001);
        end
        checkOutput("t3_goldAddr", 32'(gold_read_address), 32'h001);
        checkOutput("t3_correct",  32'(correct_count), 32'd4);
        checkOutput("t3_pass",     {31'd0, pass}, 32'd1);

        // 4: accelerator hangs, timeout after 500 cycles
        hangMode = 1'b1;
        applyStimulus("t4", 12'h000, 13'd72, 32'd500, cyc);
        checkOutput("t4_latency",  {31'd0, (cyc >= 498 && cyc <= 502)}, 32'd1);
        checkOutput("t4_timeout",  {31'd0, timeout_flag}, 32'd1);
        checkOutput("t4_dutRun",   {31'd0, dut_run}, 32'd0);
        checkOutput("t4_pass",     {31'd0, pass}, 32'd0);
        checkOutput("t4_correct",  32'(correct_count), 32'd0);
        checkOutput("t4_mismatch", 32'(mismatch_count), 32'd0);
        checkOutput("t4_rounds",   32'(round_count), 32'd4);
        hangMode = 1'b0;
        killBusy = 1'b1;
        repeat (2) @(negedge clk);
        killBusy = 1'b0;

        // 5: empty window, start held high through the whole round
        busyCycles = 10;
        addrLog.delete();
        @(negedge clk);
        base_addr      = 12'h123;
        num_results    = 13'd0;
        timeout_cycles = 32'd0;
        start          = 1'b1;
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t5_doneSeen", {31'd0, done}, 32'd1);
        start = 1'b0;
        checkOutput("t5_pass",     {31'd0, pass}, 32'd1);
        checkOutput("t5_correct",  32'(correct_count), 32'd0);
        checkOutput("t5_first",    32'(first_mismatch_addr), 32'h123);
        checkOutput("t5_noScan",   32'(addrLog.size()), 32'd0);
        checkOutput("t5_rounds",   32'(round_count), 32'd5);
        repeat (20) @(negedge clk);
        checkOutput("t5_oneRound", 32'(round_count), 32'd5);
        checkOutput("t5_idle",     {31'd0, busy}, 32'd0);

        // 6: asynchronous reset in the middle of COMPUTE
        busyCycles = 200;
        @(negedge clk);
        base_addr   = 12'h000;
        num_results = 13'd8;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("t6_preBusy",   {31'd0, busy}, 32'd1);
        checkOutput("t6_preDutBsy", {31'd0, dut_busy}, 32'd1);
        checkOutput("t6_preRounds", 32'(round_count), 32'd5);
        #3 reset_b = 1'b0;
        #1;
        checkOutput("t6_rstDutRun", {31'd0, dut_run}, 32'd0);
        checkOutput("t6_rstBusy",   {31'd0, busy}, 32'd0);
        checkOutput("t6_rstRounds", 32'(round_count), 32'd0);
        @(negedge clk);
        reset_b  = 1'b1;
        killBusy = 1'b1;
        repeat (2) @(negedge clk);
        killBusy = 1'b0;

        busyCycles = 5;
        applyStimulus("t6clean", 12'h000, 13'd8, 32'd0, cyc);
        checkOutput("t6_pass",    {31'd0, pass}, 32'd1);
        checkOutput("t6_correct", 32'(correct_count), 32'd8);
        checkOutput("t6_rounds",  32'(round_count), 32'd1);

        // tolerance words: +1, +2, and -1 vs 0 across the sign boundary
        resMem[3]  = goldMem[3] + 16'd1;
        resMem[4]  = goldMem[4] + 16'd2;
        goldMem[5] = 16'hFFFF;
        resMem[5]  = 16'h0000;
`ifdef RESULT_TOL_EN
        expCorrect  = 7;
        expMismatch = 1;
        expFirst    = 4;
`else
        expCorrect  = 5;
        expMismatch = 3;
        expFirst    = 3;
`endif
        applyStimulus("t6tol", 12'h000, 13'd8, 32'd0, cyc);
        checkOutput("t6_tolCorrect",  32'(correct_count), 32'(expCorrect));
        checkOutput("t6_tolMismatch", 32'(mismatch_count), 32'(expMismatch));
        checkOutput("t6_tolFirst",    32'(first_mismatch_addr), 32'(expFirst));
        checkOutput("t6_tolPass",     {31'd0, pass}, 32'd0);
        checkOutput("t6_tolRounds",   32'(round_count), 32'd2);
        checkDonePulse("t6tol");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dut_round_checker.md
Name: dut_round_checker

Overview:
- Synthesizable run/check sequencer for accelerator rounds: pulses dut_run, times the compute phase, then scans the result SRAM against a golden SRAM and reports correct/mismatch counts.
- Successor to the bench-side timer/comparator loop. Adds parametrised widths and depth, a base address, round counting, a timeout, first-mismatch capture and optional tolerance compare.
- Sits between a host/control block and MyDesign's run/busy handshake plus two SRAM read ports.

Parameters:
ADDR_WIDTH, 12, SRAM address width
DATA_WIDTH, 16, SRAM data width
CYC_WIDTH, 32, width of cycle and timeout counters
ROUND_WIDTH, 8, width of round counter
TOL, 1, max allowed |result-golden| when tolerance compare compiled in

Ports:
clk  in  1  clock
reset_b  in  1  asynchronous active-low reset
start  in  1  begin one round; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first result/golden address
num_results  in  ADDR_WIDTH+1  words to compare (0..2^ADDR_WIDTH)
timeout_cycles  in  CYC_WIDTH  0 = no timeout
dut_run  out  1  run request to DUT
dut_busy  in  1  DUT busy
res_read_address  out  ADDR_WIDTH  result SRAM read address
res_read_data  in  DATA_WIDTH  result SRAM data, 1-cycle latency
gold_read_address  out  ADDR_WIDTH  golden SRAM read address
gold_read_data  in  DATA_WIDTH  golden SRAM data, 1-cycle latency
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at round end
pass  out  1  mismatch_count==0 and no timeout; valid from done until next start
timeout_flag  out  1  round aborted by timeout
correct_count  out  ADDR_WIDTH+1  matching words
mismatch_count  out  ADDR_WIDTH+1  mismatching words
first_mismatch_addr  out  ADDR_WIDTH  address of first mismatch; base_addr if none
compute_cycles  out  CYC_WIDTH  cycles from dut_run rise to dut_busy fall
round_count  out  ROUND_WIDTH  completed rounds; wraps

Behaviour:
- Interface: one clock (clk); reset_b is asynchronous, active-low.
- Reset: all outputs 0, state IDLE, round_count 0.
- FSM states: IDLE, WAIT_IDLE, RUN, COMPUTE, SCAN, DRAIN, DONE.
- IDLE: on start=1, clear counts, timeout_flag, pass and compute_cycles; latch base_addr and num_results; go to WAIT_IDLE.
- WAIT_IDLE: wait for dut_busy==0, then go to RUN.
- RUN:
  - dut_run=1 from RUN entry until dut_busy==1 is sampled; then go to COMPUTE with dut_run=0 on the next cycle.
  - compute_cycles clears on RUN entry and increments every cycle in RUN and COMPUTE.
- COMPUTE: on dut_busy==0, freeze compute_cycles; go to SCAN, or to DONE if num_results==0.
- SCAN:
  - Issue addresses base_addr+i, i=0..N-1, one per cycle. Address arithmetic is mod 2^ADDR_WIDTH, so it wraps past the top.
  - A 1-deep valid pipe compares data one cycle after the address is issued.
  - After the last address, go to DRAIN.
- DRAIN: final compare, then go to DONE.
- Compare:
  - Equal: correct_count++.
  - Otherwise: mismatch_count++; first_mismatch_addr captured only on the first mismatch.
  - correct_count + mismatch_count == num_results at done.
- DONE: done=1 for one cycle; round_count++; pass updated; return to IDLE. start is ignored in DONE.
- Timeout:
  - A cycle counter runs from WAIT_IDLE onward.
  - If timeout_cycles!=0 and the counter reaches timeout_cycles in WAIT_IDLE, RUN or COMPUTE: set timeout_flag=1, drop dut_run, go to DONE with pass=0. Scan is skipped.
- start while busy: ignored.
- reset_b low mid-round: immediate return to IDLE; dut_run drops asynchronously.
- Read addresses hold their last value outside SCAN.

Optional Feature:
- Macro RESULT_TOL_EN.
- Defined: words are treated as signed DATA_WIDTH; a match is |res-gold| <= TOL, with the difference computed at DATA_WIDTH+1 bits to avoid overflow.
- Undefined: exact bitwise equality; TOL is unused.

Decomposition:
- Package dut_checker_pkg holds:
  - state enum checker_state_e
  - default width constants
- Sub-module word_compare_unit: combinational match function (exact or tolerance under RESULT_TOL_EN), instantiated once in the compare stage.

Test Plan:
1. base_addr=0, num_results=72, golden==result, DUT busy 100 cycles after run -> done pulse, pass=1, correct_count=72, mismatch_count=0, compute_cycles=101±1, round_count=1.
2. Result words 5 and 40 corrupted -> mismatch_count=2, correct_count=70, first_mismatch_addr=5, pass=0.
3. base_addr=12'hFFE, num_results=4 -> addresses FFE, FFF, 000, 001 issued in order; all match; pass=1.
4. DUT never deasserts busy, timeout_cycles=500 -> timeout_flag=1, done within 500±2 cycles of start, dut_run=0, pass=0, counts 0.
5. num_results=0 -> no SCAN addresses issued, pass=1, done after COMPUTE; start held high during busy is ignored (exactly one round).
6. reset_b pulsed low mid-COMPUTE -> dut_run, busy, round_count go 0 immediately; next start runs cleanly. With RESULT_TOL_EN and TOL=1, result=gold+1 -> counted correct; result=gold+2 -> mismatch.
